// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the 2-way set-associative data cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } cache_state_t;

  // Bits of byte-within-word offset for a given word width.
  function automatic int byte_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Bits of word-within-line offset; zero when a line holds a single word.
  function automatic int offset_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Bits of set index.
  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  // Remaining upper address bits form the tag.
  function automatic int tag_bits(input int data_w, input int sets, input int words_per_line);
    return 32 - byte_bits(data_w) - offset_bits(words_per_line) - index_bits(sets);
  endfunction

  // Zero-width fields are not legal vectors, so widths used for declarations are clamped to 1.
  function automatic int at_least_one(input int w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: valid bits, tags and line data, read asynchronously at the
// presented index. Supports a whole-line fill, a single-word store update and a
// global invalidate.
module cache_way_array #(
  parameter int DATA_W = 32,
  parameter int SETS   = 64,
  parameter int WPL    = 2,
  parameter int TAG_W  = 23,
  parameter int IDX_W  = 6,
  parameter int SEL_W  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic                  i_inval,
  input  logic                  i_line_we,
  input  logic [TAG_W-1:0]      i_line_tag,
  input  logic [WPL*DATA_W-1:0] i_line_data,
  input  logic                  i_word_we,
  input  logic [SEL_W-1:0]      i_word_sel,
  input  logic [DATA_W-1:0]     i_word_data,
  output logic                  o_valid,
  output logic [TAG_W-1:0]      o_tag,
  output logic [WPL*DATA_W-1:0] o_line
);

  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag [SETS];

  // Valid bits: cleared by reset or invalidate, set when a full line lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_inval) begin
      r_valid <= '0;
    end else if (i_line_we) begin
      r_valid[i_idx] <= 1'b1;
    end
  end

  // Tag storage is only meaningful while the matching valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (i_line_we) begin
      r_tag[i_idx] <= i_line_tag;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_tag   = r_tag[i_idx];

  // One storage array per word column so each column has a single writer.
  genvar gi;
  generate
    for (gi = 0; gi < WPL; gi++) begin : g_word
      logic [DATA_W-1:0] r_mem [SETS];

      // Line fill takes precedence; a store only touches its own word column.
      always_ff @(posedge clk) begin
        if (i_line_we) begin
          r_mem[i_idx] <= i_line_data[gi*DATA_W +: DATA_W];
        end else if (i_word_we && (int'(i_word_sel) == gi)) begin
          r_mem[i_idx] <= i_word_data;
        end
      end

      assign o_line[gi*DATA_W +: DATA_W] = r_mem[i_idx];
    end
  endgenerate

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// 2-way set-associative, write-through, no-write-allocate data cache controller
// sitting between the MEM stage and the SRAM controller. Read hits return in the
// request cycle; read misses fetch a full line word by word into the LRU victim.
module set_assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 2,
  parameter int BASE_ADDR      = 1024,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] wdata,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic              flush,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic [31:0]       sram_address,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_write,
  output logic              sram_read,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ready,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int BYTE_W     = byte_bits(DATA_W);
  localparam int OFF_W      = offset_bits(WORDS_PER_LINE);
  localparam int SEL_W      = at_least_one(OFF_W);
  localparam int IDX_W      = index_bits(SETS);
  localparam int TAG_W      = tag_bits(DATA_W, SETS, WORDS_PER_LINE);
  localparam int LINE_W     = WORDS_PER_LINE * DATA_W;
  localparam int LINE_BYTES = WORDS_PER_LINE * (DATA_W / 8);

  localparam logic [31:0] BASE_L       = 32'(BASE_ADDR);
  localparam logic [31:0] WORD_BYTES_L = 32'(DATA_W / 8);
  localparam logic [31:0] LINE_MASK_L  = ~(32'(LINE_BYTES) - 32'd1);

  cache_state_t r_state, w_state_next;

  logic [SEL_W-1:0]  r_cnt, w_cnt_next;
  logic              r_victim, w_victim_next;
  logic              r_fill_done;
  logic [LINE_W-1:0] r_fill, w_fill_line;
  logic [SETS-1:0]   r_lru;
  logic [CNT_W-1:0]  r_hit_cnt, r_miss_cnt;

  logic [31:0]       w_a, w_line_base;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [SEL_W-1:0]  w_off;

  logic [1:0]        w_valid, w_hit, w_line_we, w_word_we;
  logic [TAG_W-1:0]  w_tag_rd [2];
  logic [LINE_W-1:0] w_line [2];
  logic [LINE_W-1:0] w_hit_line;
  logic [DATA_W-1:0] w_hit_word;
  logic              w_victim_sel, w_inval, w_hit_inc, w_miss_inc, w_lru_we, w_lru_val, w_fill_capture;

  // Address split after rebasing; line base keeps only tag and index.
  assign w_a         = address - BASE_L;
  assign w_line_base = w_a & LINE_MASK_L;
  assign w_idx       = w_line_base[BYTE_W+OFF_W +: IDX_W];
  assign w_tag       = w_line_base[31 -: TAG_W];

  generate
    if (OFF_W > 0) begin : g_off
      assign w_off = w_a[BYTE_W +: SEL_W];
    end else begin : g_no_off
      assign w_off = '0;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      cache_way_array #(
        .DATA_W (DATA_W),
        .SETS   (SETS),
        .WPL    (WORDS_PER_LINE),
        .TAG_W  (TAG_W),
        .IDX_W  (IDX_W),
        .SEL_W  (SEL_W)
      ) u_way (
        .clk         (clk),
        .rst         (rst),
        .i_idx       (w_idx),
        .i_inval     (w_inval),
        .i_line_we   (w_line_we[gi]),
        .i_line_tag  (w_tag),
        .i_line_data (w_fill_line),
        .i_word_we   (w_word_we[gi]),
        .i_word_sel  (w_off),
        .i_word_data (wdata),
        .o_valid     (w_valid[gi]),
        .o_tag       (w_tag_rd[gi]),
        .o_line      (w_line[gi])
      );
      assign w_hit[gi] = w_valid[gi] && (w_tag_rd[gi] == w_tag);
    end
  endgenerate

  // At most one way can hold a given tag, so way 1 selects only on its own hit.
  assign w_hit_line = w_hit[1] ? w_line[1] : w_line[0];
  assign w_hit_word = w_hit_line[int'(w_off)*DATA_W +: DATA_W];

  // Empty ways are filled first (way 0 before way 1); otherwise the LRU way is evicted.
  assign w_victim_sel = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : r_lru[w_idx]);

  // Line being assembled: buffered words plus the word arriving this cycle.
  always_comb begin
    w_fill_line = r_fill;
    w_fill_line[int'(r_cnt)*DATA_W +: DATA_W] = sram_rdata;
  end

  // Controller next-state and outputs.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_victim_next  = r_victim;
    ready          = 1'b1;
    rdata          = '0;
    sram_read      = 1'b0;
    sram_write     = 1'b0;
    sram_address   = '0;
    sram_wdata     = '0;
    w_line_we      = 2'b00;
    w_word_we      = 2'b00;
    w_inval        = 1'b0;
    w_hit_inc      = 1'b0;
    w_miss_inc     = 1'b0;
    w_lru_we       = 1'b0;
    w_lru_val      = 1'b0;
    w_fill_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (MEM_W_EN) begin
          ready        = 1'b0;
          w_state_next = WRITE;
        end else if (MEM_R_EN) begin
          if (|w_hit) begin
            rdata = w_hit_word;
            // The cycle right after a fill returns the fetched word; that miss was already counted.
            if (!r_fill_done) begin
              w_hit_inc = 1'b1;
              w_lru_we  = 1'b1;
              w_lru_val = !w_hit[1];
            end
          end else begin
            ready         = 1'b0;
            w_miss_inc    = 1'b1;
            w_victim_next = w_victim_sel;
            w_cnt_next    = '0;
            w_state_next  = FILL;
          end
        end else if (flush) begin
          w_inval = 1'b1;
        end
      end
      FILL: begin
        ready        = 1'b0;
        sram_read    = 1'b1;
        sram_address = w_line_base + BASE_L + (32'(r_cnt) * WORD_BYTES_L);
        if (sram_ready) begin
          w_fill_capture = 1'b1;
          if (int'(r_cnt) == WORDS_PER_LINE - 1) begin
            w_line_we[r_victim] = 1'b1;
            w_lru_we            = 1'b1;
            w_lru_val           = !r_victim;
            w_state_next        = IDLE;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      WRITE: begin
        ready        = sram_ready;
        sram_write   = 1'b1;
        sram_address = address;
        sram_wdata   = wdata;
        if (sram_ready) begin
          w_word_we    = w_hit;
          w_lru_we     = |w_hit;
          w_lru_val    = !w_hit[1];
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State, word counter, victim choice and the post-fill marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_victim    <= 1'b0;
      r_fill_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_victim    <= w_victim_next;
      r_fill_done <= (r_state == FILL) && (w_state_next == IDLE);
    end
  end

  // Fill buffer accumulates words as they arrive; stale contents are never read back.
  always_ff @(posedge clk) begin
    if (w_fill_capture) begin
      r_fill <= w_fill_line;
    end
  end

  // LRU bit per set names the way to evict next.
  always_ff @(posedge clk) begin
    if (rst || w_inval) begin
      r_lru <= '0;
    end else if (w_lru_we) begin
      r_lru[w_idx] <= w_lru_val;
    end
  end

  // Saturating hit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt <= '0;
    end else if (w_hit_inc && (r_hit_cnt != '1)) begin
      r_hit_cnt <= r_hit_cnt + 1'b1;
    end
  end

  // Saturating miss counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_miss_cnt <= '0;
    end else if (w_miss_inc && (r_miss_cnt != '1)) begin
      r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench for set_assoc_cache_ctrl: cold miss, LRU replacement, write-through,
// reset mid-fill, flush and counter saturation (counters built 4 bits wide).
module tb_set_assoc_cache_ctrl;

  localparam int DATA_W = 32;
  localparam int SETS   = 64;
  localparam int WPL    = 2;
  localparam int BASE   = 1024;
  localparam int CNT_W  = 4;
  localparam int LIMIT  = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       address;
  logic [DATA_W-1:0] wdata;
  logic              MEM_R_EN, MEM_W_EN, flush;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic [31:0]       sram_address;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_write, sram_read;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_ready;
  logic [CNT_W-1:0]  hit_count, miss_count;

  int checks   = 0;
  int failures = 0;
  int sram_lat = 1;
  int cyc;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] served [$];

  always #5 clk = ~clk;

  set_assoc_cache_ctrl #(
    .DATA_W         (DATA_W),
    .SETS           (SETS),
    .WORDS_PER_LINE (WPL),
    .BASE_ADDR      (BASE),
    .CNT_W          (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .wdata        (wdata),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .flush        (flush),
    .rdata        (rdata),
    .ready        (ready),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_write   (sram_write),
    .sram_read    (sram_read),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  // Unwritten SRAM locations read back as address ^ 0xA5A50000.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Answers SRAM strobes after sram_lat idle cycles until the cache raises ready.
  task automatic serve(output int cycles);
    int lc;
    cycles = 0;
    lc = 0;
    served.delete();
    #1;
    while (!ready && cycles < LIMIT) begin
      if (sram_read || sram_write) begin
        if (lc == sram_lat) begin
          served.push_back(sram_address);
          if (sram_write) mem[sram_address] = sram_wdata;
          sram_rdata = sram_read ? mem_rd(sram_address) : 32'h0;
          sram_ready = 1'b1;
          lc = 0;
        end else begin
          lc++;
        end
      end
      #1;
      if (ready) break;
      @(negedge clk);
      sram_ready = 1'b0;
      sram_rdata = '0;
      cycles++;
      #1;
    end
  endtask

  task automatic end_txn();
    @(negedge clk);
    MEM_R_EN   = 1'b0;
    MEM_W_EN   = 1'b0;
    flush      = 1'b0;
    sram_ready = 1'b0;
    sram_rdata = '0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_data, input int exp_cyc);
    int c;
    @(negedge clk);
    address  = addr;
    MEM_R_EN = 1'b1;
    serve(c);
    chk({tag, "_lat"}, 32'(c), 32'(exp_cyc));
    chk({tag, "_data"}, rdata, exp_data);
    $display("txn %s read addr=%08h rdata=%08h cycles=%0d", tag, addr, rdata, c);
    end_txn();
  endtask

  task automatic write_do(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic fl, input int exp_cyc);
    int c;
    @(negedge clk);
    address  = addr;
    wdata    = data;
    MEM_W_EN = 1'b1;
    flush    = fl;
    serve(c);
    chk({tag, "_lat"}, 32'(c), 32'(exp_cyc));
    $display("txn %s write addr=%08h wdata=%08h cycles=%0d", tag, addr, data, c);
    end_txn();
  endtask

  initial begin
    rst = 1'b1; address = '0; wdata = '0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    flush = 1'b0; sram_rdata = '0; sram_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_sram_read", 32'(sram_read), 32'd0);
    chk("rst_sram_write", 32'(sram_write), 32'd0);
    chk("rst_sram_addr", sram_address, 32'h0);
    chk("rst_hits", 32'(hit_count), 32'd0);
    chk("rst_misses", 32'(miss_count), 32'd0);

    // 1: cold miss fetches both words, then the neighbouring word hits.
    read_chk("t1_cold", 32'h400, 32'hA5A5_0400, 5);
    chk("t1_fill_addr0", (served.size() > 0) ? served[0] : 32'hFFFF_FFFF, 32'h400);
    chk("t1_fill_addr1", (served.size() > 1) ? served[1] : 32'hFFFF_FFFF, 32'h404);
    chk("t1_hits", 32'(hit_count), 32'd0);
    chk("t1_misses", 32'(miss_count), 32'd1);
    read_chk("t1_word1", 32'h404, 32'hA5A5_0404, 0);
    chk("t1_hits2", 32'(hit_count), 32'd1);

    // 2: set 0 holds A=0x400, B=0x600; touching A makes C=0x800 evict B.
    read_chk("t2_b", 32'h600, 32'hA5A5_0600, 5);
    read_chk("t2_a", 32'h400, 32'hA5A5_0400, 0);
    read_chk("t2_c", 32'h800, 32'hA5A5_0800, 5);
    read_chk("t2_a2", 32'h400, 32'hA5A5_0400, 0);
    read_chk("t2_b2", 32'h600, 32'hA5A5_0600, 5);
    chk("t2_hits", 32'(hit_count), 32'd3);
    chk("t2_misses", 32'(miss_count), 32'd4);

    // 3: store to a cached line, strobe held while SRAM stalls.
    @(negedge clk);
    address = 32'h400; wdata = 32'hDEAD_BEEF; MEM_W_EN = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t3_hold_write", 32'(sram_write), 32'd1);
    chk("t3_hold_addr", sram_address, 32'h400);
    chk("t3_hold_wdata", sram_wdata, 32'hDEAD_BEEF);
    chk("t3_hold_ready", 32'(ready), 32'd0);
    sram_lat = 0;
    serve(cyc);
    chk("t3_done_ready", 32'(ready), 32'd1);
    $display("txn t3_st write addr=00000400 wdata=deadbeef cycles=%0d", 3 + cyc);
    end_txn();
    sram_lat = 1;
    read_chk("t3_rd", 32'h400, 32'hDEAD_BEEF, 0);
    write_do("t3_uncached", 32'h800, 32'hCAFE_F00D, 1'b0, 2);
    read_chk("t3_noalloc", 32'h800, 32'hCAFE_F00D, 5);

    // 4: reset after the first fill word abandons the fill.
    @(negedge clk);
    address = 32'h410; MEM_R_EN = 1'b1;
    @(negedge clk);
    #1;
    chk("t4_fill_rd", 32'(sram_read), 32'd1);
    chk("t4_fill_addr0", sram_address, 32'h410);
    sram_rdata = mem_rd(32'h410);
    sram_ready = 1'b1;
    @(negedge clk);
    sram_ready = 1'b0;
    #1;
    chk("t4_fill_addr1", sram_address, 32'h414);
    rst = 1'b1;
    MEM_R_EN = 1'b0;
    @(negedge clk);
    #1;
    chk("t4_rst_rd", 32'(sram_read), 32'd0);
    chk("t4_rst_addr", sram_address, 32'h0);
    chk("t4_rst_ready", 32'(ready), 32'd1);
    rst = 1'b0;
    $display("txn t4_rst read addr=00000410 abandoned by reset");
    read_chk("t4_again", 32'h410, 32'hA5A5_0410, 5);
    chk("t4_misses", 32'(miss_count), 32'd1);

    // 5: four lines cached, flush in idle empties them; flush during a store is ignored.
    read_chk("t5_l1", 32'h400, 32'hDEAD_BEEF, 5);
    read_chk("t5_l2", 32'h600, 32'hA5A5_0600, 5);
    read_chk("t5_l3", 32'h418, 32'hA5A5_0418, 5);
    read_chk("t5_hit", 32'h600, 32'hA5A5_0600, 0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    $display("txn t5_flush idle");
    read_chk("t5_f0", 32'h410, 32'hA5A5_0410, 5);
    read_chk("t5_f1", 32'h400, 32'hDEAD_BEEF, 5);
    read_chk("t5_f2", 32'h600, 32'hA5A5_0600, 5);
    read_chk("t5_f3", 32'h418, 32'hA5A5_0418, 5);
    write_do("t5_wflush", 32'h400, 32'h1111_2222, 1'b1, 2);
    read_chk("t5_kept0", 32'h400, 32'h1111_2222, 0);
    read_chk("t5_kept1", 32'h418, 32'hA5A5_0418, 0);
    chk("t5_hits", 32'(hit_count), 32'd3);
    chk("t5_misses", 32'(miss_count), 32'd8);

    // 6: 4-bit counters saturate at 15.
    for (int i = 0; i < 20; i++) begin
      read_chk("t6_hit", 32'h404, 32'hA5A5_0404, 0);
      if (i == 10) chk("t6_hits14", 32'(hit_count), 32'd14);
    end
    chk("t6_hits_sat", 32'(hit_count), 32'd15);
    for (int k = 0; k < 10; k++) begin
      read_chk("t6_miss", 32'h420 + 32'(8 * k), (32'h420 + 32'(8 * k)) ^ 32'hA5A5_0000, 5);
    end
    chk("t6_miss_sat", 32'(miss_count), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
